uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL provide parameter AW, default 4, pointer width = log2(DEPTH).
REQ-003 SHALL provide parameter AFULL, default 12, almost-full threshold in entries.
REQ-004 clk_bus  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ce  in  1  one-cycle strobe of the receiver enable (clk_div2 & clk_div4).
REQ-007 uart_rxdata  in  8  received byte from the receiver stage.
REQ-008 uart_rxrecv  in  1  byte-ready level from the receiver, changes only on ce cycles.
REQ-009 uart_data_read  out  1  acknowledge to the receiver (releases its WAIT state).
REQ-010 rd_strobe  in  1  CPU pop request, one clk_bus cycle.
REQ-011 flush  in  1  synchronous clear of FIFO contents.
REQ-012 rd_data  out  8  head-of-FIFO byte (first-word fall-through).
REQ-013 rx_avail  out  1  FIFO not empty.
REQ-014 almost_full  out  1  count >= AFULL.
REQ-015 count  out  AW+1  current occupancy, 0..DEPTH.

Function
REQ-016 SHALL detect a byte as the rising edge of uart_rxrecv (registered previous value, sampled every clk_bus).
REQ-017 SHALL run capture FSM IDLE -> PEND -> ACK -> IDLE; IDLE->PEND on detected edge, latching uart_rxdata.
REQ-018 In PEND SHALL write the latched byte at wr_ptr when not full (count<DEPTH), then go ACK; when full SHALL stay in PEND (lossless back-pressure, receiver held in WAIT).
REQ-019 In ACK SHALL drive uart_data_read=1 and leave to IDLE on the first cycle where ce=1 (acknowledge held across at least one ce cycle); uart_data_read=0 in all other states.
REQ-020 A new rxrecv edge while not IDLE SHALL be ignored (cannot occur while receiver is in WAIT).
REQ-021 rd_strobe with count>0 SHALL advance rd_ptr; rd_data SHALL show the next entry the following cycle; rd_strobe on empty SHALL be ignored.
REQ-022 Simultaneous write and pop SHALL leave count unchanged; pop on full in the same cycle as PEND write SHALL allow the write.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-024 flush SHALL zero wr_ptr, rd_ptr, count next cycle; a byte in PEND SHALL be discarded and FSM SHALL go ACK; flush has priority over write and pop.
REQ-025 rd_data SHALL be 8'h00 when empty.
REQ-026 Capture latency: byte visible on rd_data/rx_avail 2 clk_bus cycles after the rxrecv edge when not full.

Reset
REQ-027 reset_n low SHALL force FSM IDLE, pointers/count 0, uart_data_read 0, rx_avail 0, almost_full 0, rd_data 8'h00, edge register 0; RAM contents undefined.
REQ-028 Reset mid-ACK SHALL drop the acknowledge; receiver resynchronisation is the system's responsibility.

Structure
REQ-029 FSM state encodings and DEPTH/AFULL defaults SHALL live in shared package uart_pkg.
REQ-030 Storage SHALL be one sub-module, fifo_ram (DEPTH x 8, one write port, asynchronous read), inferable as distributed RAM.

Verification
REQ-031 Single byte 8'hA5 via rxrecv edge -> rx_avail=1, rd_data=8'hA5 after 2 cycles, uart_data_read high until next ce; rd_strobe -> rx_avail=0, count=0.
REQ-032 Push 16 bytes 8'h00..8'h0F, no pops -> count=16, almost_full=1 from 12th; 17th byte 8'h10 held in PEND, no ack; one pop -> 8'h10 written, ack issued, count=16.
REQ-033 Pop and PEND write in same cycle at count=16 -> count stays 16, order 8'h01..8'h10 on drain.
REQ-034 flush with 5 entries and a pending byte -> count=0, rx_avail=0, pending byte discarded, ack issued.
REQ-035 Wrap: 40 bytes pushed/popped interleaved -> output sequence equals input sequence exactly.
REQ-036 reset_n pulsed low during ACK -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive FIFO:
//   - default FIFO geometry (depth, pointer width, almost-full threshold)
//   - capture FSM state encodings (plain 2-bit constants)
package uart_pkg;

    localparam int UART_DEPTH_DEF = 16;
    localparam int UART_AW_DEF    = 4;
    localparam int UART_AFULL_DEF = 12;

    // Capture FSM: wait for a byte, hold it until it can be stored,
    // then acknowledge the receiver until its next enable strobe.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage : uart_pkg

// File: rtl/fifo_ram.sv
// fifo_ram
// DEPTH x 8 storage for the receive FIFO. One synchronous write port and
// one asynchronous read port, so the array maps onto distributed RAM and
// the FIFO head is available combinationally (first-word fall-through).
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational)
module fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // No reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side FIFO behind a UART receiver. A rising edge of uart_rxrecv
// captures uart_rxdata, the byte is written into the FIFO as soon as there
// is room, and uart_data_read then acknowledges the receiver until its next
// enable strobe. While the FIFO is full the byte waits and no acknowledge
// is given, so the receiver stays stalled and no data is lost.
// Ports:
//   clk_bus         in   sole clock
//   reset_n         in   asynchronous active-low reset
//   ce              in   receiver enable strobe
//   uart_rxdata     in   received byte
//   uart_rxrecv     in   byte-ready level from the receiver
//   uart_data_read  out  acknowledge to the receiver
//   rd_strobe       in   CPU pop request
//   flush           in   synchronous clear of FIFO contents
//   rd_data         out  head-of-FIFO byte, 8'h00 when empty
//   rx_avail        out  FIFO not empty
//   almost_full     out  count >= AFULL
//   count           out  occupancy 0..DEPTH
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH_DEF,
    parameter int AW    = UART_AW_DEF,
    parameter int AFULL = UART_AFULL_DEF
) (
    input  logic          clk_bus,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [7:0]    uart_rxdata,
    input  logic          uart_rxrecv,
    output logic          uart_data_read,
    input  logic          rd_strobe,
    input  logic          flush,
    output logic [7:0]    rd_data,
    output logic          rx_avail,
    output logic          almost_full,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL);

    logic [1:0]    state_q,  state_d;
    logic [7:0]    byte_q,   byte_d;
    logic          rxrecv_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          rx_edge;
    logic          pop_en;
    logic          wr_en;
    logic [7:0]    ram_rdata;

    assign rx_edge = uart_rxrecv & ~rxrecv_q;
    assign pop_en  = rd_strobe & (count_q != '0) & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    // the pending byte when it is being read at the same time.
    assign wr_en   = (state_q == ST_PEND) & ~flush & ((count_q != DEPTH_C) | pop_en);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_edge) begin
                    state_d = ST_PEND;
                    byte_d  = uart_rxdata;
                end
            end
            // A flush drops the pending byte but still acknowledges it so
            // the receiver is released.
            ST_PEND: begin
                if (flush || wr_en) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ce) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_bus or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            byte_q   <= 8'h00;
            rxrecv_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            rxrecv_q <= uart_rxrecv;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_bus),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (byte_q),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // All outputs decode from reset-cleared flops, so they drop to their
    // idle values as soon as reset_n falls.
    assign uart_data_read = (state_q == ST_ACK);
    assign rx_avail       = (count_q != '0);
    assign almost_full    = (count_q >= AFULL_C);
    assign rd_data        = rx_avail ? ram_rdata : 8'h00;
    assign count          = count_q;

endmodule : uart_rx_fifo
